alu_flag_datamem: RTL and testbench



---
 rtl/alu_flag_datamem_if.sv | 26 ++
 rtl/alu_flag_datamem.sv | 62 ++++++
 tb/tb_alu_flag_datamem.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_flag_datamem_if.sv
// Execution-stage bus between the control unit/register file and the
// ALU + Z flag + data memory slice.
interface alu_flag_datamem_if;
  logic [2:0] op_alu;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] alu_y;
  logic       alu_zero;
  logic       wez;
  logic       z;
  logic       mem_en;
  logic       mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_wd;
  logic [7:0] mem_rd;

  modport master (
    output op_alu, a, b, wez, mem_en, mem_we, mem_addr, mem_wd,
    input  alu_y, alu_zero, z, mem_rd
  );

  modport slave (
    input  op_alu, a, b, wez, mem_en, mem_we, mem_addr, mem_wd,
    output alu_y, alu_zero, z, mem_rd
  );
endinterface

// File: rtl/alu_flag_datamem.sv
// 8-bit ALU with combinational zero, registered Z flag and a 128x8 data
// memory with combinational read; only z is touched by reset.
module alu_flag_datamem (
  input  logic                  clk,
  input  logic                  reset,
  alu_flag_datamem_if.slave     bus
);

  logic [7:0] alu_y;
  logic       alu_zero;
  logic       z_d;
  logic       z_q;
  logic       mem_wr;
  logic [7:0] mem_q [128];

  always_comb begin
    alu_y = 8'h00;
    case (bus.op_alu)
      3'b000:  alu_y = bus.a;
      3'b001:  alu_y = ~bus.a;
      3'b010:  alu_y = bus.a + bus.b;
      3'b011:  alu_y = bus.a - bus.b;
      3'b100:  alu_y = bus.a & bus.b;
      3'b101:  alu_y = bus.a | bus.b;
      3'b110:  alu_y = ~bus.a + 8'd1;
      3'b111:  alu_y = ~bus.b + 8'd1;
      default: alu_y = 8'h00;
    endcase
  end

  assign alu_zero = (alu_y == 8'h00);

  always_comb begin
    z_d = z_q;
    if (bus.wez) begin
      z_d = alu_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      z_q <= 1'b0;
    end else begin
      z_q <= z_d;
    end
  end

  // Memory array has no reset: writes proceed even while reset is low.
  assign mem_wr = bus.mem_en & bus.mem_we;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_q[bus.mem_addr] <= bus.mem_wd;
    end
  end

  assign bus.alu_y    = alu_y;
  assign bus.alu_zero = alu_zero;
  assign bus.z        = z_q;
  assign bus.mem_rd   = bus.mem_en ? mem_q[bus.mem_addr] : 8'h00;

endmodule

// File: tb/tb_alu_flag_datamem.sv
// Self-checking bench: behavioural model compared every cycle, plus directed
// literal expectations and a randomized phase.
module tb_alu_flag_datamem;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_flag_datamem_if ifc ();

  alu_flag_datamem dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m [128];
  bit         valid_m [128];
  logic       z_m = 1'b0;
  bit         z_known = 1'b0;
  bit         chk_on = 1'b0;

  function automatic int alu_ref(int op, int a, int b);
    int r;
    case (op)
      0: r = a;
      1: r = 255 - a;
      2: r = (a + b) % 256;
      3: r = (a - b + 256) % 256;
      4: r = a & b;
      5: r = a | b;
      6: r = (256 - a) % 256;
      default: r = (256 - b) % 256;
    endcase
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state advances on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    if (!reset) begin
      z_m = 1'b0;
      z_known = 1'b1;
    end else if (ifc.wez) begin
      z_m = (alu_ref(int'(ifc.op_alu), int'(ifc.a), int'(ifc.b)) == 0);
      z_known = 1'b1;
    end
    if (ifc.mem_en && ifc.mem_we) begin
      mem_m[ifc.mem_addr] = ifc.mem_wd;
      valid_m[ifc.mem_addr] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int y;
      y = alu_ref(int'(ifc.op_alu), int'(ifc.a), int'(ifc.b));
      chk("model_alu_y", int'(ifc.alu_y), y);
      chk("model_alu_zero", int'(ifc.alu_zero), (y == 0) ? 1 : 0);
      if (z_known) chk("model_z", int'(ifc.z), int'(z_m));
      if (!ifc.mem_en) chk("model_mem_rd_off", int'(ifc.mem_rd), 0);
      else if (valid_m[ifc.mem_addr])
        chk("model_mem_rd", int'(ifc.mem_rd), int'(mem_m[ifc.mem_addr]));
    end
  end

  task automatic set_in(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic wez, input logic en, input logic we,
                        input logic [6:0] addr, input logic [7:0] wd);
    ifc.op_alu = op; ifc.a = a; ifc.b = b; ifc.wez = wez;
    ifc.mem_en = en; ifc.mem_we = we; ifc.mem_addr = addr; ifc.mem_wd = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  logic [7:0] sweep_exp [8];

  initial begin
    sweep_exp[0] = 8'h05; sweep_exp[1] = 8'hFA; sweep_exp[2] = 8'h08; sweep_exp[3] = 8'h02;
    sweep_exp[4] = 8'h01; sweep_exp[5] = 8'h07; sweep_exp[6] = 8'hFB; sweep_exp[7] = 8'hFD;

    reset = 1'b0;
    set_in(3'd0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00);
    tick();
    chk_on = 1'b1;
    at_neg();
    chk("reset_z", int'(ifc.z), 0);
    tick();
    reset = 1'b1;

    // ALU sweep
    for (int i = 0; i < 8; i++) begin
      set_in(3'(i), 8'h05, 8'h03, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00);
      at_neg();
      chk("sweep_model", alu_ref(i, 5, 3), int'(sweep_exp[i]));
      chk("sweep_alu_y", int'(ifc.alu_y), int'(sweep_exp[i]));
      chk("sweep_alu_zero", int'(ifc.alu_zero), 0);
      tick();
    end

    set_in(3'd2, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00);
    at_neg();
    chk("wrap_add_y", int'(ifc.alu_y), 0);
    chk("wrap_add_zero", int'(ifc.alu_zero), 1);
    tick();
    set_in(3'd3, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00);
    at_neg();
    chk("sub_eq_y", int'(ifc.alu_y), 0);
    chk("sub_eq_zero", int'(ifc.alu_zero), 1);
    tick();

    // Z flag load / hold / clear
    set_in(3'd3, 8'h10, 8'h10, 1'b1, 1'b0, 1'b0, 7'd0, 8'h00);
    tick();
    set_in(3'd0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00);
    at_neg();
    chk("z_set", int'(ifc.z), 1);
    tick();
    at_neg();
    chk("z_hold", int'(ifc.z), 1);
    tick();
    set_in(3'd0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 7'd0, 8'h00);
    tick();
    ifc.wez = 1'b0;
    at_neg();
    chk("z_clear", int'(ifc.z), 0);
    tick();

    // Reset beats wez
    set_in(3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 7'd0, 8'h00);
    tick();
    at_neg();
    chk("z_set_again", int'(ifc.z), 1);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ifc.wez = 1'b0;
    at_neg();
    chk("reset_priority_z", int'(ifc.z), 0);
    tick();

    // Memory write/read and enable gating
    set_in(3'd0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 7'h00, 8'hA5);
    tick();
    set_in(3'd0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 7'h7F, 8'h5A);
    tick();
    set_in(3'd0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 7'h00, 8'h00);
    at_neg();
    chk("mem_rd_00", int'(ifc.mem_rd), 8'hA5);
    tick();
    ifc.mem_addr = 7'h7F;
    at_neg();
    chk("mem_rd_7f", int'(ifc.mem_rd), 8'h5A);
    tick();
    ifc.mem_en = 1'b0;
    at_neg();
    chk("mem_rd_disabled", int'(ifc.mem_rd), 0);
    tick();
    set_in(3'd0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 7'h00, 8'h11);
    tick();
    set_in(3'd0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 7'h00, 8'h00);
    at_neg();
    chk("mem_write_gated", int'(ifc.mem_rd), 8'hA5);
    tick();

    // Read-during-write: old word before the edge, new word after
    set_in(3'd0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 7'h05, 8'h77);
    tick();
    ifc.mem_wd = 8'h33;
    at_neg();
    chk("rdw_old", int'(ifc.mem_rd), 8'h77);
    tick();
    ifc.mem_we = 1'b0;
    at_neg();
    chk("rdw_new", int'(ifc.mem_rd), 8'h33);
    tick();

    // Memory write while reset is low still lands
    set_in(3'd0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 7'h09, 8'hC3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_in(3'd0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 7'h09, 8'h00);
    at_neg();
    chk("reset_mem_write", int'(ifc.mem_rd), 8'hC3);
    chk("reset_mem_z", int'(ifc.z), 0);
    tick();

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] ra, rb;
      logic [6:0] raddr;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 8'h00;
      raddr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 15));
      set_in(3'($urandom), ra, rb, 1'($urandom), ($urandom_range(0, 3) != 0),
             1'($urandom), raddr, 8'($urandom));
      reset = ($urandom_range(0, 19) != 0);
      tick();
    end

    at_neg();
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
